// File: rtl/dsp_sdm_out.sv
// dsp_sdm_out: one-deep sample buffer, frame-rate loader and first-order delta-sigma PDM output.
// Define DSP_SDM_DITHER_EN to add LFSR dither (1 LSB) on the modulator input.
module dsp_sdm_out #(
    parameter int BITS    = 16,
    parameter int FPWIDTH = 12,
    parameter int DIV     = 256
) (
    input  logic                   clk,
    input  logic                   rst_n,
    input  logic signed [BITS-1:0] sample_in,
    input  logic                   sample_valid,
    output logic                   sample_ready,
    output logic                   frame_tick,
    output logic                   pdm_out,
    output logic [7:0]             underrun_cnt
);
    localparam int CW = $clog2(DIV);
    localparam int EW = (BITS > FPWIDTH + 2) ? BITS : FPWIDTH + 2;
    localparam logic signed [EW-1:0] CLIP_MAX = EW'((2 ** FPWIDTH) - 1);
    localparam logic signed [EW-1:0] CLIP_MIN = EW'(-(2 ** FPWIDTH));
    localparam logic [CW-1:0] LAST = CW'(DIV - 1);

    typedef enum logic {IDLE, RUN} state_t;

    logic [CW-1:0]          cnt_q, cnt_d;
    logic signed [FPWIDTH:0] hold_q, cur_q, clamped;
    logic                   holdFull_q;
    logic [FPWIDTH:0]       acc_q, acc_d;
    logic                   pdm_q, pdm_d;
    logic [7:0]             underrun_q;
    state_t                 state_q;
    logic signed [EW-1:0]   sampleExt;
    logic                   transfer;
    logic [FPWIDTH:0]       u, uMod;
    logic [FPWIDTH+1:0]     sum;

    // Widen before clamping so a BITS narrower or wider than the clip range both work.
    assign sampleExt = EW'(sample_in);

    always_comb begin
        clamped = sampleExt[FPWIDTH:0];
        if (sampleExt > CLIP_MAX) begin
            clamped = CLIP_MAX[FPWIDTH:0];
        end else if (sampleExt < CLIP_MIN) begin
            clamped = CLIP_MIN[FPWIDTH:0];
        end
    end

    assign frame_tick   = (cnt_q == LAST);
    assign sample_ready = !holdFull_q;
    assign transfer     = sample_valid && !holdFull_q;
    assign cnt_d        = frame_tick ? '0 : cnt_q + CW'(1);

    // Adding 2^FPWIDTH to a two's-complement value is just flipping its sign bit.
    assign u = {~cur_q[FPWIDTH], cur_q[FPWIDTH-1:0]};

`ifdef DSP_SDM_DITHER_EN
    logic [15:0]        lfsr_q;
    logic [FPWIDTH+1:0] uWide;

    assign uWide = {1'b0, u} + {{(FPWIDTH + 1){1'b0}}, lfsr_q[0]};
    assign uMod  = uWide[FPWIDTH+1] ? '1 : uWide[FPWIDTH:0];

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            lfsr_q <= 16'hACE1;
        end else begin
            lfsr_q <= {lfsr_q[14:0], lfsr_q[15] ^ lfsr_q[13] ^ lfsr_q[12] ^ lfsr_q[10]};
        end
    end
`else
    assign uMod = u;
`endif

    assign sum   = {1'b0, acc_q} + {1'b0, uMod};
    assign pdm_d = sum[FPWIDTH+1];
    assign acc_d = sum[FPWIDTH:0];

    // On the frame-load cycle the buffer is drained, or an arriving sample bypasses it.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            cnt_q      <= '0;
            acc_q      <= '0;
            pdm_q      <= 1'b0;
            cur_q      <= '0;
            hold_q     <= '0;
            holdFull_q <= 1'b0;
            underrun_q <= '0;
            state_q    <= IDLE;
        end else begin
            cnt_q <= cnt_d;
            acc_q <= acc_d;
            pdm_q <= pdm_d;
            if (frame_tick) begin
                if (holdFull_q) begin
                    cur_q      <= hold_q;
                    holdFull_q <= 1'b0;
                    state_q    <= RUN;
                end else if (transfer) begin
                    cur_q   <= clamped;
                    state_q <= RUN;
                end else if (state_q == RUN && underrun_q != 8'hFF) begin
                    underrun_q <= underrun_q + 8'd1;
                end
            end else if (transfer) begin
                hold_q     <= clamped;
                holdFull_q <= 1'b1;
            end
        end
    end

    assign pdm_out      = pdm_q;
    assign underrun_cnt = underrun_q;

endmodule

// File: doc/dsp_sdm_out.md
Name: dsp_sdm_out

Overview:
- Audio output stage directly downstream of the saturating adder/mixer.
- Accepts one clipped signed fixed-point sample per output frame through a valid/ready handshake and buffers it.
- Converts it to a 1-bit pulse-density stream with a first-order delta-sigma modulator, for an external RC filter on an FPGA pin.
- Detects and counts frames where no new sample arrived (underrun).

Parameters:
- BITS, 16, width of the signed sample bus (matches mixer output width).
- FPWIDTH, 12, upstream clip range is -(2^FPWIDTH) .. 2^FPWIDTH-1.
- DIV, 256, clocks per output frame (sample period); must be 2 or more.

Ports:
- clk  in  1  system clock
- rst_n  in  1  synchronous active-low reset
- sample_in  in  BITS  signed sample from mixer
- sample_valid  in  1  sample_in is valid this cycle
- sample_ready  out  1  block can accept a sample this cycle
- frame_tick  out  1  one-cycle pulse on the frame-load cycle
- pdm_out  out  1  pulse-density output bit
- underrun_cnt  out  8  saturating count of frames with no new sample

Behaviour:
- Clock and reset: one clock, clk. Reset is synchronous and active-low (rst_n), sampled on the rising edge of clk.
- Reset values:
  - pdm_out=0, frame_tick=0, underrun_cnt=0.
  - Frame counter=0, accumulator=0, current sample=0.
  - Hold buffer empty, so sample_ready=1.
  - State=IDLE.
  - Reset mid-operation discards any buffered sample and the modulator state.
- Frame counter:
  - Counts 0..DIV-1 and wraps to 0.
  - frame_tick is combinational, high when count==DIV-1.
- Handshake:
  - sample_ready = !hold_full.
  - A transfer occurs when valid && ready; sample_in is captured into the hold register and hold_full is set.
  - sample_valid while ready is low is ignored; upstream holds the sample until ready.
- Input clamp: the captured sample is clamped to [-(2^FPWIDTH), 2^FPWIDTH-1], in case BITS exceeds the clip range.
- Frame load (frame_tick cycle):
  - If hold_full: cur <= hold, hold_full <= 0, state <= RUN.
  - Else if a transfer occurs this same cycle (buffer empty): the incoming clamped sample goes directly to cur, hold stays empty, state <= RUN.
  - Else: cur is unchanged. If state==RUN, underrun_cnt increments, saturating at 255. In IDLE the counter does not change.
- States:
  - IDLE: no sample ever loaded.
  - RUN: at least one sample loaded.
  - IDLE->RUN on the first load. RUN->IDLE only on reset.
- Modulator (runs every cycle, in both states):
  - u = cur + 2^FPWIDTH, unsigned, range 0..2^(FPWIDTH+1)-1.
  - sum = acc + u, FPWIDTH+2 bits.
  - pdm_out <= sum[FPWIDTH+1]; acc <= sum[FPWIDTH:0].
  - Long-run density = u / 2^(FPWIDTH+1).
- Density boundaries:
  - cur=0 gives 50% density: alternating bits 0,1,0,1 from reset.
  - cur=-(2^FPWIDTH) gives constant 0.
  - cur=2^FPWIDTH-1 gives one 0 per 2^(FPWIDTH+1) cycles.
- Latency: a new cur is registered on the frame-load edge. The first pdm_out bit that depends on it appears one cycle after that edge.

Optional Feature:
- Macro: DSP_SDM_DITHER_EN.
- Defined:
  - Adds a 16-bit Fibonacci LFSR (taps 16,14,13,11; seed 16'hACE1 on reset), advanced every cycle.
  - u_d = u + lfsr[0], clamped to 2^(FPWIDTH+1)-1, replaces u in the sum.
  - Breaks idle tones at the cost of 1 LSB of noise.
- Not defined: no LFSR; u is used directly. Output is fully deterministic as specified above.

Test Plan:
All scenarios use BITS=8, FPWIDTH=4, DIV=8, dither off.
- Reset, no input -> pdm_out=0 during reset; afterwards 0,1,0,1... every cycle; sample_ready=1; underrun_cnt stays 0 across 3 frames (IDLE).
- Send 15 once, then nothing -> after the load, pdm_out has exactly 31 ones in every 32-cycle window. Then send -16 -> after the next load, pdm_out constant 0.
- Send 100 -> clamped to 15, same density as 15. Send -100 -> clamped to -16, constant 0.
- Two back-to-back valids (5 then 7) mid-frame -> 5 accepted and sample_ready drops; 7 held off until the frame_tick cycle; then 5 moves to cur and 7 is accepted on the following cycle.
- Valid asserted exactly on the frame_tick cycle with empty buffer -> sample goes straight to cur, sample_ready stays 1, no underrun counted.
- After the first sample, withhold input for 3 frames -> underrun_cnt=3 and density unchanged. Assert rst_n=0 for one cycle mid-frame -> all outputs return to reset values and the 0,1 pattern restarts.
